// File: rtl/alu_byte_seq.sv
// Multi-byte ALU sequencer: walks up to MAXB bytes of two operands through an
// external 8-bit ALU, least-significant byte first, chaining the carry.
module alu_byte_seq #(
    parameter int unsigned MAXB = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*MAXB-1:0]    op_a,
    input  logic [8*MAXB-1:0]    op_b,
    input  logic [2:0]           op_acode,
    input  logic [1:0]           op_len,
    input  logic                 op_cin,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_acode,
    output logic [1:0]           alu_scode,
    output logic                 alu_is_shift,
    output logic                 alu_carry_in,
    input  logic [7:0]           alu_r,
    input  logic                 alu_zero,
    input  logic                 alu_carry_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [8*MAXB-1:0]    result,
    output logic                 res_zero,
    output logic                 res_carry
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [8*MAXB-1:0]   a_q, a_d;
    logic [8*MAXB-1:0]   b_q, b_d;
    logic [2:0]          acode_q, acode_d;
    logic [1:0]          len_q, len_d;
    logic                cin_q, cin_d;
    logic [1:0]          idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic [8*MAXB-1:0]   result_q, result_d;
    logic                res_zero_q, res_zero_d;
    logic                res_carry_q, res_carry_d;
    logic                supported;
    logic [4:0]          bit_base;

    // Opcodes this sequencer knows how to chain: add, adc, and, or, xor.
    always_comb begin
        case (op_acode)
            3'b000, 3'b001, 3'b100, 3'b101, 3'b110: supported = 1'b1;
            default:                                supported = 1'b0;
        endcase
    end

    assign bit_base = {idx_q, 3'b000};

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acode_d     = acode_q;
        len_d       = len_q;
        cin_d       = cin_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        result_d    = result_q;
        res_zero_d  = res_zero_q;
        res_carry_d = res_carry_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (supported) begin
                        a_d         = op_a;
                        b_d         = op_b;
                        acode_d     = op_acode;
                        len_d       = op_len;
                        cin_d       = op_cin;
                        idx_d       = 2'd0;
                        carry_d     = 1'b0;
                        zero_d      = 1'b1;
                        result_d    = '0;
                        res_zero_d  = 1'b0;
                        res_carry_d = 1'b0;
                        state_d     = EXEC;
                    end else begin
                        // Rejected request leaves all latched state untouched.
                        state_d = ERR;
                    end
                end
            end
            EXEC: begin
                result_d[bit_base +: 8] = alu_r;
                carry_d                 = alu_carry_out;
                zero_d                  = zero_q & alu_zero;
                idx_d                   = idx_q + 2'd1;
                if (idx_q == len_q) begin
                    res_carry_d = alu_carry_out;
                    res_zero_d  = zero_q & alu_zero;
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acode_q     <= 3'b000;
            len_q       <= 2'd0;
            cin_q       <= 1'b0;
            idx_q       <= 2'd0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acode_q     <= acode_d;
            len_q       <= len_d;
            cin_q       <= cin_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            result_q    <= result_d;
            res_zero_q  <= res_zero_d;
            res_carry_q <= res_carry_d;
        end
    end

    // ALU drive: active only in EXEC; upper bytes of add chains become adc.
    always_comb begin
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_acode    = 3'b000;
        alu_scode    = 2'b00;
        alu_is_shift = 1'b0;
        alu_carry_in = 1'b0;
        if (state_q == EXEC) begin
            alu_a = a_q[bit_base +: 8];
            alu_b = b_q[bit_base +: 8];
            if (idx_q == 2'd0) begin
                alu_acode    = acode_q;
                alu_carry_in = cin_q;
            end else begin
                alu_acode    = (acode_q[2:1] == 2'b00) ? 3'b001 : acode_q;
                alu_carry_in = carry_q;
            end
        end
    end

    assign busy      = (state_q == EXEC);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign result    = result_q;
    assign res_zero  = res_zero_q;
    assign res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_byte_seq.sv
// Directed bench for alu_byte_seq with a 9-bit reference ALU in the loop.
module tb_alu_byte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_acode;
    logic [1:0]  op_len;
    logic        op_cin;
    logic [7:0]  alu_a, alu_b, alu_r;
    logic [2:0]  alu_acode;
    logic [1:0]  alu_scode;
    logic        alu_is_shift, alu_carry_in, alu_zero, alu_carry_out;
    logic        busy, done, err;
    logic [31:0] result;
    logic        res_zero, res_carry;
    logic [8:0]  alu_sum;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen;

    alu_byte_seq #(.MAXB(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_acode     (op_acode),
        .op_len       (op_len),
        .op_cin       (op_cin),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_acode    (alu_acode),
        .alu_scode    (alu_scode),
        .alu_is_shift (alu_is_shift),
        .alu_carry_in (alu_carry_in),
        .alu_r        (alu_r),
        .alu_zero     (alu_zero),
        .alu_carry_out(alu_carry_out),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result       (result),
        .res_zero     (res_zero),
        .res_carry    (res_carry)
    );

    always #5 clk = ~clk;

    // Reference 8-bit ALU with 9-bit unsigned sum.
    always_comb begin
        alu_sum = 9'd0;
        case (alu_acode)
            3'b000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
            3'b100: alu_sum = {1'b0, alu_a & alu_b};
            3'b101: alu_sum = {1'b0, alu_a | alu_b};
            3'b110: alu_sum = {1'b0, alu_a ^ alu_b};
            default: alu_sum = 9'd0;
        endcase
    end
    assign alu_r         = alu_sum[7:0];
    assign alu_carry_out = alu_sum[8];
    assign alu_zero      = (alu_sum[7:0] == 8'h00);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ac,
                         input logic [1:0] len, input logic cin);
        op_a     = a;
        op_b     = b;
        op_acode = ac;
        op_len   = len;
        op_cin   = cin;
        start    = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        op_a = '0; op_b = '0; op_acode = 3'b000; op_len = 2'd0; op_cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_zero", res_zero, 0);
        check("rst_carry", res_carry, 0);
        check("rst_alu_a", alu_a, 0);

        // 4-byte add with carry ripple through bytes 1..3
        issue(32'h00FF_FFFF, 32'h0000_0001, 3'b000, 2'd3, 1'b0);
        tick(); start = 1'b0;
        check("add_b0_busy", busy, 1);
        check("add_b0_a", alu_a, 32'hFF);
        check("add_b0_b", alu_b, 32'h01);
        check("add_b0_acode", alu_acode, 3'b000);
        check("add_b0_cin", alu_carry_in, 0);
        check("add_b0_ctl", {alu_is_shift, alu_scode}, 0);
        // mid-EXEC start with a different op must be ignored
        issue(32'h1111_1111, 32'h2222_2222, 3'b110, 2'd0, 1'b0);
        tick(); start = 1'b0;
        check("add_b1_acode", alu_acode, 3'b001);
        check("add_b1_cin", alu_carry_in, 1);
        check("add_b1_a", alu_a, 32'hFF);
        tick();
        check("add_b2_acode", alu_acode, 3'b001);
        check("add_b2_cin", alu_carry_in, 1);
        tick();
        check("add_b3_busy", busy, 1);
        check("add_b3_acode", alu_acode, 3'b001);
        check("add_b3_a", alu_a, 32'h00);
        tick();
        check("add_done", done, 1);
        check("add_busy_off", busy, 0);
        check("add_result", result, 32'h0100_0000);
        check("add_zero", res_zero, 0);
        check("add_carry", res_carry, 0);
        check("add_alu_idle", alu_a, 0);

        // back-to-back start during DONE: 1-byte xor
        issue(32'h0000_005A, 32'h0000_005A, 3'b110, 2'd0, 1'b0);
        tick(); start = 1'b0;
        check("xor_busy", busy, 1);
        check("xor_acode", alu_acode, 3'b110);
        tick();
        check("xor_done", done, 1);
        check("xor_result", result, 0);
        check("xor_zero", res_zero, 1);
        check("xor_carry", res_carry, 0);
        tick();
        check("xor_idle", done, 0);

        // 2-byte or to leave a nonzero result behind
        issue(32'h0000_1234, 32'h0000_0F0F, 3'b101, 2'd1, 1'b0);
        tick(); start = 1'b0;
        tick(); tick();
        check("or_done", done, 1);
        check("or_result", result, 32'h0000_1F3F);
        tick();

        // unsupported opcode: err pulse, no done, result held
        issue(32'hDEAD_BEEF, 32'h1234_5678, 3'b010, 2'd3, 1'b0);
        tick(); start = 1'b0;
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_done", done, 0);
        check("bad_result", result, 32'h0000_1F3F);
        tick();
        check("bad_err_off", err, 0);
        check("bad_done_off", done, 0);
        check("bad_result_held", result, 32'h0000_1F3F);

        // carry-in chain through two bytes
        issue(32'h0000_FFFF, 32'h0000_0000, 3'b001, 2'd1, 1'b1);
        tick(); start = 1'b0;
        check("cc_b0_cin", alu_carry_in, 1);
        tick();
        check("cc_b1_cin", alu_carry_in, 1);
        tick();
        check("cc_done", done, 1);
        check("cc_result", result, 0);
        check("cc_zero", res_zero, 1);
        check("cc_carry", res_carry, 1);
        tick();

        // reset at idx 2 of a 4-byte op
        issue(32'h0102_0304, 32'h1020_3040, 3'b000, 2'd3, 1'b0);
        tick(); start = 1'b0;
        tick(); tick();
        check("rm_b2_a", alu_a, 32'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_busy", busy, 0);
        check("rm_result", result, 0);
        check("rm_done", done, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("rm_no_done", done_seen, 0);

        // reset wins over start in the same cycle
        issue(32'h0000_0001, 32'h0000_0001, 3'b000, 2'd0, 1'b0);
        rst = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        check("rp_busy", busy, 0);
        check("rp_acode", alu_acode, 0);
        check("rp_cin", alu_carry_in, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_byte_seq.md
ALU_BYTE_SEQ -- requirements
Module: alu_byte_seq

Interface
REQ-001 Parameter: MAXB, 4, maximum operand length in bytes; fixed at 4 in this revision.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a multi-byte operation; sampled only in IDLE or DONE.
REQ-005 op_a, op_b  in  32 each  operands; byte 0 = bits [7:0].
REQ-006 op_acode  in  3  ALU operation code.
REQ-007 op_len  in  2  operand length minus one (00 = 1 byte … 11 = 4 bytes).
REQ-008 op_cin  in  1  carry into byte 0.
REQ-009 alu_a, alu_b  out  8 each  byte operands to the 8-bit ALU.
REQ-010 alu_acode  out  3; alu_scode  out  2; alu_is_shift  out  1; alu_carry_in  out  1  ALU controls.
REQ-011 alu_r  in  8; alu_zero  in  1; alu_carry_out  in  1  ALU results.
REQ-012 busy  out  1  high in EXEC.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  one-cycle pulse; unsupported opcode rejected.
REQ-015 result  out  32; res_zero  out  1; res_carry  out  1  final results.

Function
REQ-016 FSM states: IDLE, EXEC, DONE, ERR.
REQ-017 Supported op_acode values: 000 (add), 001 (add with carry), 100 (and), 101 (or), 110 (xor).
REQ-018 IDLE/DONE with start=1 and a supported opcode: latch op_a, op_b, op_acode, op_len, op_cin; clear result; set byte index idx=0; go to EXEC.
REQ-019 IDLE/DONE with start=1 and an unsupported opcode (010, 011, 111): go to ERR; latched operands and result are unchanged.
REQ-020 ERR lasts exactly one cycle with err=1, then goes to IDLE.
REQ-021 DONE lasts one cycle with done=1, then goes to IDLE unless a new start is accepted in that cycle.
REQ-022 EXEC alu_a/alu_b: combinationally driven with latched byte idx of A/B.
REQ-023 EXEC control outputs: alu_is_shift=0; alu_scode=00.
REQ-024 EXEC byte 0: alu_acode=latched acode; alu_carry_in=latched op_cin.
REQ-025 EXEC bytes 1..len: alu_acode=001 when latched acode is 000 or 001, else latched acode; alu_carry_in=carry register.
REQ-026 Each EXEC cycle samples alu_r into result byte idx and alu_carry_out into the carry register; zero accumulator &= alu_zero, initialised to 1 on accept.
REQ-027 EXEC sequencing: idx increments each cycle; after the cycle with idx==op_len, go to DONE.
REQ-028 Latency: op_len+1 EXEC cycles; done asserts op_len+2 cycles after the start cycle.
REQ-029 In DONE: res_carry=carry register; res_zero=zero accumulator.
REQ-030 Holding: result/res_zero/res_carry hold until the next accepted start; result bytes above op_len read 0.
REQ-031 start during EXEC or ERR is ignored and not queued.
REQ-032 Outside EXEC, all alu_* outputs drive 0.
REQ-033 Output timing: busy, done, and err are mutually exclusive and registered from state.

Reset
REQ-034 rst=1 at a clock edge: state IDLE, idx=0, busy=0, done=0, err=0, result=0, res_zero=0, res_carry=0, carry and zero registers 0.
REQ-035 rst during EXEC aborts the operation: no done pulse, result=0.
REQ-036 rst has priority over start in the same cycle.

Verification (bench drives alu_r/alu_zero/alu_carry_out from an unsigned 9-bit reference ALU model)
REQ-037 4-byte add: start, a=0x00FFFFFF, b=0x00000001, acode=000, len=11, cin=0 -> busy 4 cycles; alu_carry_in=1 on bytes 1,2; alu_acode=001 on bytes 1-3; done in cycle 5 with result=0x01000000, res_zero=0, res_carry=0.
REQ-038 1-byte xor: a=0x5A, b=0x5A, acode=110, len=00 -> one EXEC cycle, done at cycle 2, result=0x00000000, res_zero=1.
REQ-039 Unsupported opcode: start with acode=010 -> err pulses the next cycle, done never asserts, previous result held.
REQ-040 Start ignored while busy: second start mid-EXEC -> no effect; back-to-back start during DONE -> accepted, busy next cycle.
REQ-041 Reset mid-operation: rst asserted at EXEC idx=2 of a 4-byte op -> next cycle IDLE, result=0, no done.
REQ-042 Carry-in chain: a=0xFFFF, b=0x0000, acode=001, cin=1, len=01 -> result=0x00000000, res_zero=1, res_carry=1.
